// File: rtl/gpio_display_ctrl_pkg.sv
// Shared types and constants for the GPIO display controller: FSM states,
// active-low segment glyphs ({g,f,e,d,c,b,a}) and double-dabble iteration count.
package gpio_disp_pkg;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index 0 is the glyph for digit 0 (lowest slice).
  localparam logic [9:0][6:0] SEG_GLYPH = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam int unsigned DD_ITERS = 32;

  // Largest value representable on the display: 10^digits - 1.
  function automatic logic [31:0] max_value(input int unsigned digits);
    logic [31:0] v;
    v = 32'd1;
    for (int unsigned i = 0; i < digits; i++) v = v * 32'd10;
    return v - 32'd1;
  endfunction

endpackage

// File: rtl/gpio_display_ctrl_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Dash has priority over blank; non-decimal nibbles show blank.
module bcd_to_seg7
  import gpio_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash)                seg = SEG_DASH;
    else if (blank)          seg = SEG_BLANK;
    else if (nibble <= 4'd9) seg = SEG_GLYPH[nibble];
  end

endmodule

// File: rtl/gpio_display_ctrl.sv
// GPIO display controller: iterative double-dabble of CPU writes onto
// seven-segment digits, plus switch synchronizer. Macro GPIO_DISP_BLANK_EN enables leading-zero blanking.
module gpio_display_ctrl
  import gpio_disp_pkg::*;
#(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned SW_WIDTH    = 18,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           gpio_out,
  input  logic                  gpio_we,
  input  logic [SW_WIDTH-1:0]   sw,
  output logic [31:0]           gpio_in,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  ovf
);

  localparam int unsigned BW      = 4 * DIGITS;
  localparam logic [31:0] MAX_VAL = max_value(DIGITS);

  state_t          state, state_next;
  logic [31:0]     bin, pend_data, src;
  logic [BW-1:0]   bcd, bcd_adj, disp;
  logic [4:0]      cnt;
  logic            ovf_flag, pend_valid;
  logic            take_pend, direct, start, capture, src_ovf, last_iter;
  logic [DIGITS-1:0] blank;

  // A pending write always wins over a fresh write in IDLE/LOAD; the fresh one
  // then becomes the new pending value so nothing is lost.
  always_comb begin
    take_pend = pend_valid && (state == IDLE || state == LOAD);
    direct    = (state == IDLE) && !pend_valid && gpio_we;
    start     = take_pend || direct;
    capture   = gpio_we && !direct;
    src       = take_pend ? pend_data : gpio_out;
    src_ovf   = src > MAX_VAL;
    last_iter = (cnt == 5'(DD_ITERS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = src_ovf ? LOAD : CONV;
      CONV:    if (last_iter) state_next = LOAD;
      LOAD:    if (start) state_next = src_ovf ? LOAD : CONV;
               else       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE) || pend_valid;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      ovf_flag   <= 1'b0;
      ovf        <= 1'b0;
      disp       <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      if (capture) begin
        pend_valid <= 1'b1;
        pend_data  <= gpio_out;
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end
      if (state == LOAD) begin
        disp <= bcd;
        ovf  <= ovf_flag;
      end
      if (start) begin
        bin      <= src;
        bcd      <= '0;
        cnt      <= '0;
        ovf_flag <= src_ovf;
      end else if (state == CONV) begin
        bcd <= {bcd_adj[BW-2:0], bin[31]};
        bin <= {bin[30:0], 1'b0};
        cnt <= cnt + 5'd1;
      end
    end
  end

`ifdef GPIO_DISP_BLANK_EN
  logic seen_nz;
  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (disp[4*(DIGITS-1-k) +: 4] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz && k != DIGITS - 1) blank[DIGITS-1-k] = 1'b1;
    end
  end
`else
  always_comb begin
    blank = '0;
  end
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_to_seg7 u_seg (
      .nibble (disp[4*g +: 4]),
      .blank  (blank[g]),
      .dash   (ovf),
      .seg    (hex[7*g +: 7])
    );
  end

  logic [SW_WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gpio_in = 32'(sync_q[SYNC_STAGES-1]);

endmodule
